alu_request_arbiter: RTL and testbench

Two-requester front end for the basic ALU library: subtractor, NAND, leading-ones counter and one-hot decoder. It arbitrates between two command ports with round-robin fairness and captures the granted command. It runs one operation through the shared combinational units, registers the result with its flags, and holds it on a valid/ready result port until consumed. A wrapping counter tracks completed operations.

---
 rtl/alu_request_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_request_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// Two-port round-robin front end for a shared subtract / NAND / leading-ones / one-hot ALU.
// One command in flight at a time; the result is held on a valid/ready port until consumed.
module alu_request_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [1:0]       i_req0_op,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [1:0]       i_req1_op,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_y,
    output logic             o_res_overflow,
    output logic             o_res_err,
    output logic             o_res_id,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_op_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [2*WIDTH-1:0] VEC_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]     CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t             state_q;
    logic               ptr_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               id_q;
    logic               res_valid_q;
    logic [WIDTH-1:0]   res_y_q;
    logic               res_ov_q;
    logic               res_err_q;
    logic               res_id_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               req0_rdy_s;
    logic               req1_rdy_s;
    logic [2*WIDTH-1:0] vec_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH:0]     lo_cnt_s;
    logic               lo_run_s;
    logic [WIDTH:0]     oh_idx_s;
    logic [WIDTH-1:0]   alu_y_d;
    logic               alu_ov_d;
    logic               alu_err_d;

    // Grant: sole requester wins, otherwise the pointer decides; only in IDLE.
    always_comb begin
        req0_rdy_s = 1'b0;
        req1_rdy_s = 1'b0;
        if (state_q == IDLE) begin
            req0_rdy_s = i_req0_valid & (~i_req1_valid | ~ptr_q);
            req1_rdy_s = i_req1_valid & (~i_req0_valid | ptr_q);
        end else begin
            req0_rdy_s = 1'b0;
            req1_rdy_s = 1'b0;
        end
    end

    assign o_req0_ready = req0_rdy_s;
    assign o_req1_ready = req1_rdy_s;

    // Shared units on the captured operands; counts/indices carry one extra bit for overflow.
    always_comb begin
        vec_s    = {b_q, a_q};
        diff_s   = a_q - b_q;
        lo_cnt_s = '0;
        lo_run_s = 1'b1;
        oh_idx_s = '0;
        for (int i = 2*WIDTH-1; i >= 0; i--) begin
            if (lo_run_s && vec_s[i]) begin
                lo_cnt_s = lo_cnt_s + CNT_ONE;
            end else begin
                lo_run_s = 1'b0;
            end
            if (vec_s[i]) begin
                oh_idx_s = (WIDTH+1)'(i);
            end else begin
                oh_idx_s = oh_idx_s;
            end
        end
        case (op_q)
            2'b00: begin
                alu_y_d   = diff_s;
                alu_ov_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_s[WIDTH-1] != a_q[WIDTH-1]);
                alu_err_d = 1'b0;
            end
            2'b01: begin
                alu_y_d   = ~(a_q & b_q);
                alu_ov_d  = 1'b0;
                alu_err_d = 1'b0;
            end
            2'b10: begin
                alu_y_d   = lo_cnt_s[WIDTH-1:0];
                alu_ov_d  = lo_cnt_s[WIDTH];
                alu_err_d = 1'b0;
            end
            2'b11: begin
                alu_y_d   = oh_idx_s[WIDTH-1:0];
                alu_ov_d  = oh_idx_s[WIDTH];
                alu_err_d = ((vec_s & (vec_s - VEC_ONE)) != '0);
            end
            default: begin
                alu_y_d   = '0;
                alu_ov_d  = 1'b0;
                alu_err_d = 1'b0;
            end
        endcase
    end

    // Control FSM with all result outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_ov_q    <= 1'b0;
            res_err_q   <= 1'b0;
            res_id_q    <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_rdy_s || req1_rdy_s) begin
                        op_q    <= req1_rdy_s ? i_req1_op : i_req0_op;
                        a_q     <= req1_rdy_s ? i_req1_a  : i_req0_a;
                        b_q     <= req1_rdy_s ? i_req1_b  : i_req0_b;
                        id_q    <= req1_rdy_s;
                        ptr_q   <= req0_rdy_s;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_y_q     <= alu_y_d;
                    res_ov_q    <= alu_ov_d;
                    res_err_q   <= alu_err_d;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (i_res_ready) begin
                        res_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign o_res_valid    = res_valid_q;
    assign o_res_y        = res_y_q;
    assign o_res_overflow = res_ov_q;
    assign o_res_err      = res_err_q;
    assign o_res_id       = res_id_q;
    assign o_busy         = busy_q;
    assign o_op_count     = cnt_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter: unit results, round-robin grants, hold, wrap, reset.
module tb_alu_request_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_req0_valid, i_req1_valid;
    logic       o_req0_ready, o_req1_ready;
    logic [1:0] i_req0_op, i_req1_op;
    logic [3:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic       o_res_valid, i_res_ready;
    logic [3:0] o_res_y;
    logic       o_res_overflow, o_res_err, o_res_id, o_busy;
    logic [7:0] o_op_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    alu_request_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_op(i_req0_op), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_op(i_req1_op), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_y(o_res_y), .o_res_overflow(o_res_overflow), .o_res_err(o_res_err),
        .o_res_id(o_res_id), .o_busy(o_busy), .o_op_count(o_op_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, o_res_valid, 0);
        check({tag, "_y"}, o_res_y, 0);
        check({tag, "_flags"}, {o_res_overflow, o_res_err, o_res_id}, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_cnt"}, o_op_count, 0);
    endtask

    task automatic run_op(input logic port, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] ey, input logic eov, input logic eerr);
        if (port) begin
            i_req1_op = op; i_req1_a = a; i_req1_b = b; i_req1_valid = 1'b1;
        end else begin
            i_req0_op = op; i_req0_a = a; i_req0_b = b; i_req0_valid = 1'b1;
        end
        #1;
        check("rdy_sel", port ? o_req1_ready : o_req0_ready, 1);
        check("rdy_oth", port ? o_req0_ready : o_req1_ready, 0);
        step();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        #1;
        check("exec_busy", o_busy, 1);
        check("exec_valid", o_res_valid, 0);
        step();
        check("res_valid", o_res_valid, 1);
        check("res_y", o_res_y, ey);
        check("res_ov", o_res_overflow, eov);
        check("res_err", o_res_err, eerr);
        check("res_id", o_res_id, port);
        i_res_ready = 1'b1;
        step();
        i_res_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("hs_valid", o_res_valid, 0);
        check("hs_busy", o_busy, 0);
        check("hs_cnt", o_op_count, exp_cnt);
    endtask

    initial begin
        i_rst = 1'b1;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_res_ready = 1'b0;
        i_req0_op = 2'b00; i_req0_a = 4'h0; i_req0_b = 4'h0;
        i_req1_op = 2'b00; i_req1_a = 4'h0; i_req1_b = 4'h0;
        #1;
        check_all_zero("rst");
        step(); step();
        i_rst = 1'b0;
        step();

        run_op(1'b0, 2'b00, 4'b0011, 4'b1010, 4'b1001, 1'b1, 1'b0);
        run_op(1'b1, 2'b01, 4'b1100, 4'b1010, 4'b0111, 1'b0, 1'b0);
        run_op(1'b0, 2'b10, 4'b1000, 4'b1111, 4'b0101, 1'b0, 1'b0);
        run_op(1'b1, 2'b11, 4'b0000, 4'b0010, 4'b0101, 1'b0, 1'b0);
        run_op(1'b0, 2'b11, 4'b0000, 4'b0011, 4'b0100, 1'b0, 1'b1);
        run_op(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_op(1'b0, 2'b10, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_op(1'b1, 2'b00, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0);
        run_op(1'b0, 2'b00, 4'b0101, 4'b0010, 4'b0011, 1'b0, 1'b0);
        run_op(1'b1, 2'b10, 4'b1111, 4'b1111, 4'b1000, 1'b0, 1'b0);
        run_op(1'b0, 2'b11, 4'b0100, 4'b0000, 4'b0010, 1'b0, 1'b0);

        // Consumer stalls for five cycles in HOLD
        i_req1_op = 2'b01; i_req1_a = 4'hF; i_req1_b = 4'hF; i_req1_valid = 1'b1;
        step();
        i_req1_valid = 1'b0;
        step();
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_valid", o_res_valid, 1);
            check("hold_y", o_res_y, 4'h0);
            check("hold_id", o_res_id, 1);
            check("hold_rdy", {o_req0_ready, o_req1_ready}, 0);
            check("hold_cnt", o_op_count, exp_cnt);
        end
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        i_res_ready = 1'b1;
        step();
        i_res_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("rel_valid", o_res_valid, 0);
        check("rel_busy", o_busy, 0);
        check("rel_cnt", o_op_count, exp_cnt);

        // Round-robin from reset with both ports always requesting
        i_rst = 1'b1;
        #1;
        check_all_zero("rst2");
        exp_cnt = 8'd0;
        step();
        i_rst = 1'b0;
        i_req0_op = 2'b01; i_req0_a = 4'h0; i_req0_b = 4'h0;
        i_req1_op = 2'b00; i_req1_a = 4'h1; i_req1_b = 4'h1;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1; i_res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_rdy0", o_req0_ready, (k % 2) == 0);
            check("rr_rdy1", o_req1_ready, (k % 2) == 1);
            check("rr_two", o_req0_ready & o_req1_ready, 0);
            step();
            check("rr_exec_rdy", {o_req0_ready, o_req1_ready}, 0);
            step();
            check("rr_id", o_res_id, k % 2);
            check("rr_y", o_res_y, ((k % 2) == 0) ? 4'hF : 4'h0);
            step();
        end
        check("rr_cnt", o_op_count, 8'd4);
        repeat (251 * 3) step();
        check("pre_wrap_cnt", o_op_count, 8'd255);
        repeat (3) step();
        check("wrap_cnt", o_op_count, 8'd0);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_res_ready = 1'b0;
        step();

        // Reset while a result is held
        i_req0_op = 2'b00; i_req0_a = 4'b0011; i_req0_b = 4'b1010; i_req0_valid = 1'b1;
        step();
        i_req0_valid = 1'b0;
        step(); step();
        check("pre_rst_valid", o_res_valid, 1);
        i_rst = 1'b1;
        #1;
        check_all_zero("hold_rst");
        step();
        i_rst = 1'b0;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        #1;
        check("ptr_rdy0", o_req0_ready, 1);
        check("ptr_rdy1", o_req1_ready, 0);
        step();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        step();
        check("post_rst_id", o_res_id, 0);
        check("post_rst_y", o_res_y, 4'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
